// File: rtl/ad9235_axil_capture.sv
// AXI4-Lite register slave with a capture FIFO for AD9235 12-bit samples.
// Optional macro AD9235_TWOS_COMP_EN: DATA reads return sign-extended two's complement.
module ad9235_axil_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [11:0]                       adc_data,
  input  logic                              adc_otr,
  input  logic                              adc_valid,
  output logic                              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_SCRATCH = 2'd1,
    REG_STATUS  = 2'd2,
    REG_DATA    = 2'd3
  } reg_sel_e;

  logic           r_bvalid, r_rvalid;
  logic [31:0]    r_rdata;
  logic [1:0]     r_rresp;
  logic           r_en, r_irq_en, r_ovf, r_otr, r_irq;
  logic [7:0]     r_thresh;
  logic [31:0]    r_scratch;
  logic [LW-1:0]  r_wptr, r_rptr;
  logic [11:0]    r_mem [FIFO_DEPTH];

  reg_sel_e       w_wsel, w_rsel;
  logic           w_wr_en, w_rd_en, w_flush, w_pop;
  logic           w_push_req, w_push_ok, w_set_ovf, w_set_otr, w_clr_ovf, w_clr_otr;
  logic [LW-1:0]  w_level;
  logic [8:0]     w_level9;
  logic           w_empty, w_full;
  logic [11:0]    w_head;
  logic [31:0]    w_head_word, w_rd_word;
  logic [1:0]     w_rd_resp;
  logic           w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Handshakes are combinational so a write/read is accepted in the cycle it is offered.
  assign w_wr_en = s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
  assign w_rd_en = s00_axi_arvalid & ~r_rvalid;
  assign w_wsel  = reg_sel_e'(s00_axi_awaddr[3:2]);
  assign w_rsel  = reg_sel_e'(s00_axi_araddr[3:2]);

  assign s00_axi_awready = w_wr_en;
  assign s00_axi_wready  = w_wr_en;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_arready = w_rd_en;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rvalid  = r_rvalid;
  assign irq             = r_irq;

  assign w_level  = r_wptr - r_rptr;
  assign w_level9 = 9'(w_level);
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == LW'(FIFO_DEPTH));
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  assign w_flush    = w_wr_en & (w_wsel == REG_CTRL) & s00_axi_wstrb[0] & s00_axi_wdata[1];
  assign w_pop      = w_rd_en & (w_rsel == REG_DATA) & ~w_empty;
  assign w_push_req = r_en & ~w_flush & adc_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_set_ovf  = w_push_req & w_full & ~w_pop;
  assign w_set_otr  = w_push_req & adc_otr;
  assign w_clr_ovf  = w_wr_en & (w_wsel == REG_STATUS) & s00_axi_wstrb[2] & s00_axi_wdata[18];
  assign w_clr_otr  = w_wr_en & (w_wsel == REG_STATUS) & s00_axi_wstrb[2] & s00_axi_wdata[19];

`ifdef AD9235_TWOS_COMP_EN
  logic [11:0] w_signed;
  assign w_signed    = w_head ^ 12'h800;
  assign w_head_word = {{20{w_signed[11]}}, w_signed};
`else
  assign w_head_word = {20'b0, w_head};
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    w_rd_word = '0;
    w_rd_resp = RESP_OKAY;
    unique case (w_rsel)
      REG_CTRL:    w_rd_word = {16'b0, r_thresh, 5'b0, r_irq_en, 1'b0, r_en};
      REG_SCRATCH: w_rd_word = r_scratch;
      REG_STATUS:  w_rd_word = {12'b0, r_otr, r_ovf, w_full, w_empty, 7'b0, w_level9};
      REG_DATA: begin
        if (w_empty) w_rd_resp = RESP_SLVERR;
        else         w_rd_word = w_head_word;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_wr_en)             r_bvalid <= 1'b1;
      else if (s00_axi_bready) r_bvalid <= 1'b0;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
        r_rresp  <= w_rd_resp;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_thresh  <= '0;
      r_scratch <= '0;
      r_ovf     <= 1'b0;
      r_otr     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_en && w_wsel == REG_CTRL) begin
        if (s00_axi_wstrb[0]) begin
          r_en     <= s00_axi_wdata[0];
          r_irq_en <= s00_axi_wdata[2];
        end
        if (s00_axi_wstrb[1]) r_thresh <= s00_axi_wdata[15:8];
      end
      if (w_wr_en && w_wsel == REG_SCRATCH) begin
        for (int b = 0; b < 4; b++)
          if (s00_axi_wstrb[b]) r_scratch[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
      // A new event in the clearing cycle wins over the clear.
      r_ovf <= (r_ovf & ~w_clr_ovf) | w_set_ovf;
      r_otr <= (r_otr & ~w_clr_otr) | w_set_otr;
      r_irq <= r_irq_en & (r_ovf | ((r_thresh != '0) && (w_level9 >= {1'b0, r_thresh})));
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
    end
  end

  // NOTE: sample storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= adc_data;
  end

endmodule

// File: doc/ad9235_axil_capture.md
# ad9235_axil_capture

AXI4-Lite responder that sits inside the AD9235 peripheral IP between the processor-side AXI4-Lite master and the AD9235 12-bit parallel ADC sample path. It buffers ADC samples in a small FIFO and exposes control and status registers. It also provides a pop-on-read data port and a level/overflow interrupt. It is the slave end of the same register interface the peripheral's AXI4-Lite master bench drives.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; four word registers.
- FIFO_DEPTH, 16, sample FIFO depth; must be a power of 2, range 4..256.
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr/awprot/awvalid  in  4/3/1  write address channel; awprot is ignored.
- s00_axi_awready  out  1  write address accept.
- s00_axi_wdata/wstrb/wvalid  in  32/4/1  write data channel.
- s00_axi_wready  out  1  write data accept.
- s00_axi_bresp/bvalid  out  2/1  write response.
- s00_axi_bready  in  1  write response accept.
- s00_axi_araddr/arprot/arvalid  in  4/3/1  read address channel; arprot is ignored.
- s00_axi_arready  out  1  read address accept.
- s00_axi_rdata/rresp/rvalid  out  32/2/1  read data channel.
- s00_axi_rready  in  1  read data accept.
- adc_data  in  12  AD9235 sample, offset binary, already in the s00_axi_aclk domain.
- adc_otr  in  1  out-of-range flag, qualified by adc_valid.
- adc_valid  in  1  one-cycle sample strobe.
- irq  out  1  level-high interrupt, registered.

## Operation
- Register map, selected by address bits [3:2]:
  - 0x0 CTRL, RW: bit0 EN; bit1 FLUSH (self-clearing, always reads 0); bit2 IRQ_EN; [15:8] THRESH; other bits read 0.
  - 0x4 SCRATCH: 32-bit RW; honours wstrb per byte.
  - 0x8 STATUS: [8:0] level; bit16 empty; bit17 full; bit18 OVF sticky; bit19 OTR sticky. Writing 1 to bit18 or bit19 clears that bit; all other bits are read-only.
  - 0xC DATA, RO: a read pops the FIFO head. Writes have no effect and return OKAY.
- CTRL writes honour wstrb byte 0 and byte 1 only.
- Capture: when EN=1, FLUSH is not active and adc_valid=1, {adc_data} is pushed. If adc_otr=1 on that push, OTR is set. If the FIFO is full, the sample is dropped and OVF is set.
- FIFO uses read and write pointers with one extra wrap bit. Level = wptr − rptr, width log2(FIFO_DEPTH)+1.
- Push and pop in the same cycle while full: both happen, level unchanged, OVF not set.
- Push and pop in the same cycle while empty: the pop sees empty, and the sample is stored.
- FLUSH write: pointers reset at the end of the write-accept cycle. This takes priority over a push or pop in that cycle. Contents are discarded; sticky bits are kept.
- Clearing EN stops pushes; FIFO contents are retained.
- Empty DATA read: rdata=0, rresp=SLVERR (2'b10), no pop. Every other access returns OKAY.
- irq = IRQ_EN & (OVF | (THRESH≠0 & level ≥ THRESH)).

## Timing
- Write: awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid. The register updates on that edge. bvalid rises the next cycle and holds until bready. No new write is accepted while bvalid=1.
- Read: arready pulses for one cycle when arvalid & !rvalid. rdata/rresp are registered on that edge. rvalid rises the next cycle and holds, stable, until rready. The pop occurs on the arready cycle.
- Read and write in the same cycle are handled independently. The read returns the pre-write value.
- A sample pushed in cycle N is readable by a read accepted in cycle N+1 or later.
- irq updates one cycle after the condition changes.
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, irq 0, all registers 0, FIFO empty. Asserting reset mid-transaction aborts it immediately. bvalid and rvalid drop asynchronously.

## Configuration
- AD9235_TWOS_COMP_EN defined: DATA returns (sample ^ 0x800) sign-extended from bit 11 to 32 bits.
- AD9235_TWOS_COMP_EN undefined: DATA returns the raw offset-binary sample zero-extended to 32 bits.

## Test plan
- Write 0x1,0x2,0x3,0x4 to addresses 0x0/0x4/0x8/0xC, then read back → CTRL=0x00000001 (EN); SCRATCH=0x00000002; STATUS=0x00010000 (bits 0x3 not writable); DATA read → 0x0 with SLVERR.
- Write SCRATCH 0xFFFFFFFF, then 0x00000000 with wstrb=4'b0101 → read 0xFF00FF00.
- CTRL=0x0405, then push 0x000,0x7FF,0x800,0xFFF → irq=1 on the cycle after level=4. Reads with the macro: 0xFFFFF800, 0xFFFFFFFF, 0x00000000, 0x000007FF. Reads without the macro: 0x000, 0x7FF, 0x800, 0xFFF. irq=0 after the first pop.
- EN=1, 17 pushes, 1 with adc_otr=1 → STATUS=0x000E0010. Write 0x000C0000 to STATUS → 0x00020010.
- Full FIFO, DATA read accepted in the same cycle as a push → level stays 16, OVF stays 0.
- FLUSH with 5 samples held → STATUS=0x00010000 on the next read. Reset asserted while rvalid=1 → rvalid=0 at once, CTRL=0.
